// File: rtl/rd_addr_n_arb_pkg.sv
// Shared types and helpers for the N-memory read-address arbiter.
package rd_addr_n_arb_pkg;

  // Only the two low instruction bits are decoded.
  typedef enum logic [1:0] {
    INSTR_STP = 2'd0,
    INSTR_EVP = 2'd1,
    INSTR_EVB = 2'd2,
    INSTR_RST = 2'd3
  } instr_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  // Ceiling log2 with a floor of 1, so a depth of 1 or 2 still gets a 1-bit index.
  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rd_addr_n_arb_rr_pick.sv
// Combinational winner picker: fixed priority (lowest index) or round-robin
// search starting at ptr and wrapping at N_CH.
module rd_addr_n_arb_rr_pick
  import rd_addr_n_arb_pkg::*;
#(
  parameter  int N_CH = 4,
  localparam int CH_W = clog2_min1(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  input  logic            mode_rr,
  output logic [N_CH-1:0] win,
  output logic [CH_W-1:0] win_idx,
  output logic            any
);

  logic [CH_W-1:0] cand;

  // Walk channels in priority order and keep the first requester.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the loop can leave it unassigned and infer a latch.
    win     = '0;
    win_idx = '0;
    any     = 1'b0;
    cand    = '0;
    for (int k = 0; k < N_CH; k++) begin
      cand = mode_rr ? CH_W'((int'(ptr) + k) % N_CH) : CH_W'(k);
      if (!any && req[cand]) begin
        any       = 1'b1;
        win_idx   = cand;
        win[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rd_addr_n_arb.sv
// Registered multi-channel read-address arbiter for the N coefficient memory.
// Holds the IDLE/GRANT/LOCKED FSM, round-robin pointer, burst owner, address
// select with range check, and the output registers (one cycle latency).
module rd_addr_n_arb
  import rd_addr_n_arb_pkg::*;
#(
  parameter  int n_size = 8,
  parameter  int N_CH   = 4,
  localparam int ADDR_W = clog2_min1(n_size),
  localparam int CH_W   = clog2_min1(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             instr,
  input  logic [N_CH-1:0]        req,
  input  logic [N_CH-1:0]        lock,
  input  logic [N_CH*ADDR_W-1:0] rd_addr_in,
  output logic [ADDR_W-1:0]      rd_addr_N,
  output logic                   rd_en,
  output logic [N_CH-1:0]        gnt,
  output logic [CH_W-1:0]        rd_ch,
  output logic                   addr_err,
  output logic                   busy
);

  instr_e            mode;
  logic              unused_instr_hi;
  logic [ADDR_W-1:0] ch_addr [N_CH];

  state_e            state_q,    state_d;
  logic [CH_W-1:0]   owner_q,    owner_d;
  logic [CH_W-1:0]   rr_ptr_q,   rr_ptr_d;
  logic [ADDR_W-1:0] rd_addr_q,  rd_addr_d;
  logic              rd_en_q,    rd_en_d;
  logic [N_CH-1:0]   gnt_q,      gnt_d;
  logic [CH_W-1:0]   rd_ch_q,    rd_ch_d;
  logic              addr_err_q, addr_err_d;

  logic [N_CH-1:0]   pick_win;
  logic [CH_W-1:0]   pick_idx;
  logic              pick_any;

  logic              hold;
  logic              win_any;
  logic [CH_W-1:0]   win_idx;
  logic [N_CH-1:0]   win_oh;
  logic [ADDR_W-1:0] win_addr;
  logic              addr_ok;

  assign mode            = instr_e'(instr[1:0]);
  assign unused_instr_hi = ^instr[7:2];

  for (genvar c = 0; c < N_CH; c++) begin : g_addr
    assign ch_addr[c] = rd_addr_in[c*ADDR_W +: ADDR_W];
  end

  rd_addr_n_arb_rr_pick #(.N_CH(N_CH)) u_pick (
    .req     (req),
    .ptr     (rr_ptr_q),
    .mode_rr (mode == INSTR_EVB),
    .win     (pick_win),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  // Winner selection: a live burst owner keeps the port, otherwise arbitrate.
  always_comb begin
    hold     = (state_q == ST_LOCKED) && req[owner_q] && lock[owner_q];
    win_any  = hold || pick_any;
    win_idx  = hold ? owner_q : pick_idx;
    win_oh   = hold ? (N_CH'(1) << owner_q) : pick_win;
    win_addr = ch_addr[win_idx];
    addr_ok  = int'(win_addr) < n_size;
  end

  // Next-state and next-output computation for all registers.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    rd_addr_d  = rd_addr_q;
    rd_ch_d    = rd_ch_q;
    rd_en_d    = 1'b0;
    gnt_d      = '0;
    addr_err_d = 1'b0;
    case (mode)
      INSTR_RST: begin
        state_d   = ST_IDLE;
        owner_d   = '0;
        rr_ptr_d  = '0;
        rd_addr_d = '0;
        rd_ch_d   = '0;
      end
      INSTR_STP: ;  // outputs drop to idle, everything else frozen
      default: begin
        if (!win_any) begin
          state_d = ST_IDLE;
        end else begin
          if (hold) begin
            state_d = ST_LOCKED;
          end else if (lock[win_idx]) begin
            state_d = ST_LOCKED;
            owner_d = win_idx;
          end else begin
            state_d = ST_GRANT;
          end
          rr_ptr_d = (int'(win_idx) == N_CH - 1) ? '0 : win_idx + 1'b1;
          if (addr_ok) begin
            rd_en_d   = 1'b1;
            gnt_d     = win_oh;
            rd_ch_d   = win_idx;
            rd_addr_d = win_addr;
          end else begin
            addr_err_d = 1'b1;
          end
        end
      end
    endcase
  end

  // State and output registers, cleared immediately by rst.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values, independent of statement order.
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      rd_addr_q  <= '0;
      rd_en_q    <= 1'b0;
      gnt_q      <= '0;
      rd_ch_q    <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      rd_addr_q  <= rd_addr_d;
      rd_en_q    <= rd_en_d;
      gnt_q      <= gnt_d;
      rd_ch_q    <= rd_ch_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign rd_addr_N = rd_addr_q;
  assign rd_en     = rd_en_q;
  assign gnt       = gnt_q;
  assign rd_ch     = rd_ch_q;
  assign addr_err  = addr_err_q;
  assign busy      = (state_q == ST_LOCKED);

endmodule
